// File: rtl/ad9826_pkg.sv
// rtl/ad9826_pkg.sv - shared constants and FSM states for the AD9826 serial slave
package ad9826_pkg;

  localparam int FRAME_LEN = 16;
  localparam int HDR_LEN   = 7;
  localparam int DATA_W    = 9;
  localparam int ADDR_W    = 3;
  localparam int NUM_REGS  = 1 << ADDR_W;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] POS_RW       = 5'd0;
  localparam logic [CNT_W-1:0] POS_ADDR_LO  = 5'd1;
  localparam logic [CNT_W-1:0] POS_ADDR_HI  = 5'd3;
  localparam logic [CNT_W-1:0] POS_HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] POS_DATA_HI  = CNT_W'(FRAME_LEN - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR      = 3'd1;
  localparam logic [2:0] ST_WDATA    = 3'd2;
  localparam logic [2:0] ST_RDATA    = 3'd3;
  localparam logic [2:0] ST_WAIT_END = 3'd4;

endpackage

// File: rtl/ad9826_sync_edge.sv
// rtl/ad9826_sync_edge.sv - N-stage synchronizer with rise/fall pulses on the synced level
module ad9826_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/ad9826_serial_slave.sv
// rtl/ad9826_serial_slave.sv - AD9826 3-wire serial port responder emulating the 8 x 9-bit register file
module ad9826_serial_slave
  import ad9826_pkg::*;
#(
  parameter bit LSB_FIRST   = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        sload,
  input  logic        sdata_in,
  output logic        sdata_out,
  output logic        sdata_oe,
  output logic [71:0] cfg_regs,
  output logic        wr_strobe,
  output logic [2:0]  wr_addr,
  output logic        rd_strobe,
  output logic        frame_err
);

  logic w_sclk_q, w_sclk_rise, w_sclk_fall;
  logic w_sload_q, w_sload_rise, w_sload_fall;
  logic w_sd, w_sd_rise, w_sd_fall;
  logic w_unused;

  ad9826_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_d(sclk),
    .o_q(w_sclk_q), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  ad9826_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sload (
    .clk(clk), .rst_n(rst_n), .i_d(sload),
    .o_q(w_sload_q), .o_rise(w_sload_rise), .o_fall(w_sload_fall)
  );

  ad9826_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(clk), .rst_n(rst_n), .i_d(sdata_in),
    .o_q(w_sd), .o_rise(w_sd_rise), .o_fall(w_sd_fall)
  );

  assign w_unused = ^{w_sclk_q, w_sload_q, w_sd_rise, w_sd_fall};

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [2:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_rd_shift;
  logic              r_wr_pend;
  logic              r_overrun;

  assign cfg_regs = r_regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs     <= '0;
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_shift <= '0;
      r_wr_pend  <= 1'b0;
      r_overrun  <= 1'b0;
      sdata_out  <= 1'b0;
      sdata_oe   <= 1'b0;
      wr_strobe  <= 1'b0;
      wr_addr    <= '0;
      rd_strobe  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      rd_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (w_sload_rise) begin
        sdata_oe <= 1'b0;
        r_state  <= ST_IDLE;
        if (r_state == ST_WAIT_END && !r_overrun) begin
          if (r_wr_pend) begin
            r_regs[r_addr] <= r_data;
            wr_strobe      <= 1'b1;
            wr_addr        <= r_addr;
          end else begin
            rd_strobe <= 1'b1;
          end
        end else if (r_state != ST_IDLE) begin
          // A rise with no frame open (e.g. tail of a reset-interrupted frame) is not an error
          frame_err <= 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_sload_fall) begin
              r_state   <= ST_HDR;
              r_bit_cnt <= '0;
              sdata_oe  <= 1'b0;
              r_wr_pend <= 1'b0;
              r_overrun <= 1'b0;
            end
          end
          ST_HDR: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == POS_RW)
                r_rw <= w_sd;
              if (r_bit_cnt >= POS_ADDR_LO && r_bit_cnt <= POS_ADDR_HI)
                r_addr <= LSB_FIRST ? {w_sd, r_addr[ADDR_W-1:1]} : {r_addr[ADDR_W-2:0], w_sd};
              if (r_bit_cnt == POS_HDR_LAST) begin
                if (r_rw) begin
                  r_state    <= ST_RDATA;
                  r_rd_shift <= r_regs[r_addr];
                end else begin
                  r_state <= ST_WDATA;
                end
              end
            end
          end
          ST_WDATA: begin
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              r_data    <= LSB_FIRST ? {w_sd, r_data[DATA_W-1:1]} : {r_data[DATA_W-2:0], w_sd};
              if (r_bit_cnt == POS_DATA_HI) begin
                r_state   <= ST_WAIT_END;
                r_wr_pend <= 1'b1;
              end
            end
          end
          ST_RDATA: begin
            // Drive on falls so the master sees each bit settled well before its rise
            if (w_sclk_fall) begin
              sdata_oe   <= 1'b1;
              sdata_out  <= LSB_FIRST ? r_rd_shift[0] : r_rd_shift[DATA_W-1];
              r_rd_shift <= LSB_FIRST ? {1'b0, r_rd_shift[DATA_W-1:1]}
                                      : {r_rd_shift[DATA_W-2:0], 1'b0};
            end
            if (w_sclk_rise) begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == POS_DATA_HI)
                r_state <= ST_WAIT_END;
            end
          end
          ST_WAIT_END: begin
            if (w_sclk_rise)
              r_overrun <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
